// File: rtl/ram_sp_arb2.sv
// Round-robin arbiter for two requesters sharing one single-port synchronous RAM.
// Requests are granted combinationally; read data returns one cycle after acceptance with no response backpressure.
module ram_sp_arb2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic             s0_we,
  input  logic [AW-1:0]    s0_addr,
  input  logic [WIDTH-1:0] s0_wdata,
  output logic             s0_rvalid,
  output logic [WIDTH-1:0] s0_rdata,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic             s1_we,
  input  logic [AW-1:0]    s1_addr,
  input  logic [WIDTH-1:0] s1_wdata,
  output logic             s1_rvalid,
  output logic [WIDTH-1:0] s1_rdata,
  output logic             ram_cen,
  output logic             ram_wen,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  typedef struct packed {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  logic last;
  logic rd_pend;
  logic rd_id;
  logic gnt0;
  logic gnt1;
  req_t req_sel;

  // last==1 means port 1 was served most recently, so port 0 wins a tie.
  assign gnt0 = !rst && s0_valid && (!s1_valid || last);
  assign gnt1 = !rst && s1_valid && (!s0_valid || !last);

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;

  always_comb begin
    req_sel = '0;
    if (gnt0) begin
      req_sel = '{we: s0_we, addr: s0_addr, wdata: s0_wdata};
    end else if (gnt1) begin
      req_sel = '{we: s1_we, addr: s1_addr, wdata: s1_wdata};
    end
  end

  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = 1'b1;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0 || gnt1) begin
      ram_cen  = 1'b0;
      ram_wen  = !req_sel.we;
      ram_addr = req_sel.addr;
      ram_din  = req_sel.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        last <= gnt1;
      end
      rd_pend <= (gnt0 || gnt1) && !req_sel.we;
      rd_id   <= gnt1;
    end
  end

  // RAM output register and rd_pend advance on the same edge, so no extra data stage.
  assign s0_rvalid = rd_pend && !rd_id;
  assign s1_rvalid = rd_pend && rd_id;
  assign s0_rdata  = ram_dout;
  assign s1_rdata  = ram_dout;

endmodule
